// File: rtl/apb_master.sv
// APB3 requester: turns one-shot valid/ready commands into APB SETUP/ACCESS
// transfers toward a single completer, returns read data and error status,
// and aborts transfers whose completer holds PREADY low for too long.
module apb_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PSLVERR
);

   // Wide enough to hold TIMEOUT-1; a 1-bit dummy when the watchdog is off.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    wait_q;
   logic                psel_q;
   logic                penable_q;
   logic                pwrite_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic [DATA_W-1:0]   pwdata_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                rsp_err_q;
   logic                timeout_hit;

   // This ACCESS cycle is the TIMEOUT-th consecutive wait: abort at this edge.
   assign timeout_hit = (TIMEOUT != 0) && (int'(wait_q) == TIMEOUT - 1);

   // Ready is a pure decode of the state register, so it is high out of reset.
   assign cmd_ready = (state_q == IDLE);

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // Transfer FSM with all APB and response outputs registered.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         // Response strobe lasts exactly one cycle; data/err hold until next completion.
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  pwrite_q <= cmd_write;
                  paddr_q  <= cmd_addr;
                  pwdata_q <= cmd_wdata;
                  wait_q   <= '0;
                  psel_q   <= 1'b1;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= PSLVERR;
                  rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                  state_q     <= IDLE;
               end else if (timeout_hit) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  state_q     <= IDLE;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers compared against a cycle-count / result model of APB3 timing.
module tb_apb_master;

   localparam int TIMEOUT = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA;
   logic        PREADY = 1'b0;
   logic [31:0] PRDATA = '0;
   logic        PSLVERR = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          psel_n;
      int          pen_n;
      int          lat;
      bit          setup_ok;
      bit          stable;
      bit          got;
      bit          rdy;
      bit          next_lo;
      bit          hold;
      logic [31:0] rd;
      logic        err;
   } obs_t;

   apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // Reference model: cycles from command acceptance to the response being visible,
   // and how many cycles PENABLE is high, derived from the APB3 phase rules.
   function automatic bit is_to(input int waits);
      return waits >= TIMEOUT;
   endfunction
   function automatic int exp_lat(input int waits);
      return is_to(waits) ? TIMEOUT + 2 : waits + 3;
   endfunction
   function automatic int exp_pen(input int waits);
      return is_to(waits) ? TIMEOUT : waits + 1;
   endfunction

   // Issue one command and act as the completer, inserting 'waits' PREADY-low ACCESS cycles.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int waits,
                       input logic err, input logic [31:0] rd, output obs_t o);
      int acc;
      o = '{default: 0};
      acc = 0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      @(negedge PCLK);
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
      o.stable = 1'b1;
      for (int c = 0; c < 64 && !o.got; c++) begin
         o.lat++;
         if (c == 0) o.setup_ok = (PSEL === 1'b1 && PENABLE === 1'b0);
         if (rsp_valid === 1'b1) begin
            o.got = 1'b1; o.rd = rsp_rdata; o.err = rsp_err; o.rdy = (cmd_ready === 1'b1);
         end
         if (PSEL === 1'b1) o.psel_n++;
         if (PENABLE === 1'b1) o.pen_n++;
         if (PSEL === 1'b1 && (PADDR !== a || PWRITE !== wr || (wr && PWDATA !== wd))) o.stable = 1'b0;
         if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            PREADY  = (acc == waits);
            PSLVERR = (acc == waits) ? err : 1'($urandom);
            PRDATA  = (acc == waits) ? rd : $urandom;
            acc++;
         end else begin
            PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
         end
         if (!o.got) @(negedge PCLK);
      end
      PREADY = 1'b0; PSLVERR = 1'b0;
      if (o.got) begin
         @(negedge PCLK);
         o.next_lo = (rsp_valid === 1'b0);
         o.hold    = (rsp_rdata === o.rd && rsp_err === o.err);
      end
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      @(negedge PCLK);
      n_vec++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rd=%h re=%b, want all 0",
                  PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err);
      end
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      n_vec++;
      if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
         n_err++; $display("FAIL reset_release: cmd_ready=%b psel=%b, want 1/0", cmd_ready, PSEL);
      end
   endtask

   task automatic test_write();
      obs_t o;
      xfer(1'b1, 32'h4, 32'hA5A5_0001, 0, 1'b0, 32'h1234_5678, o);
      n_vec++;
      if (!o.got || o.lat != 3) begin n_err++; $display("FAIL wr_latency: got=%0b lat=%0d, want 1/3", o.got, o.lat); end
      n_vec++;
      if (o.psel_n != 2 || o.pen_n != 1 || !o.setup_ok) begin
         n_err++; $display("FAIL wr_phases: psel=%0d pen=%0d setup=%0b, want 2/1/1", o.psel_n, o.pen_n, o.setup_ok);
      end
      n_vec++;
      if (!o.stable) begin n_err++; $display("FAIL wr_stable: PADDR/PWRITE/PWDATA moved, want 4/1/a5a50001"); end
      n_vec++;
      if (o.rd !== 32'h0 || o.err !== 1'b0 || !o.rdy || !o.next_lo) begin
         n_err++; $display("FAIL wr_rsp: rd=%h err=%b rdy=%0b pulse1=%0b, want 0/0/1/1", o.rd, o.err, o.rdy, o.next_lo);
      end
   endtask

   task automatic test_read_wait();
      obs_t o;
      xfer(1'b0, 32'h8, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, o);
      n_vec++;
      if (o.pen_n != 4 || o.lat != 6 || !o.stable) begin
         n_err++; $display("FAIL rd_wait: pen=%0d lat=%0d stable=%0b, want 4/6/1", o.pen_n, o.lat, o.stable);
      end
      n_vec++;
      if (o.rd !== 32'hDEAD_BEEF || o.err !== 1'b0 || !o.hold) begin
         n_err++; $display("FAIL rd_data: rd=%h err=%b hold=%0b, want deadbeef/0/1", o.rd, o.err, o.hold);
      end
   endtask

   task automatic test_slverr();
      obs_t o;
      xfer(1'b0, 32'h20, 32'h0, 1, 1'b1, 32'h0BAD_F00D, o);
      n_vec++;
      if (!o.got || o.err !== 1'b1 || o.rd !== 32'h0BAD_F00D) begin
         n_err++; $display("FAIL slverr: got=%0b err=%b rd=%h, want 1/1/0badf00d", o.got, o.err, o.rd);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      int late;
      xfer(1'b0, 32'h30, 32'h0, TIMEOUT + 4, 1'b0, 32'hFFFF_FFFF, o);
      n_vec++;
      if (!o.got || o.lat != TIMEOUT + 2 || o.pen_n != TIMEOUT) begin
         n_err++; $display("FAIL to_timing: got=%0b lat=%0d pen=%0d, want 1/%0d/%0d", o.got, o.lat, o.pen_n, TIMEOUT + 2, TIMEOUT);
      end
      n_vec++;
      if (o.err !== 1'b1 || o.rd !== 32'h0 || !o.rdy) begin
         n_err++; $display("FAIL to_rsp: err=%b rd=%h rdy=%0b, want 1/0/1", o.err, o.rd, o.rdy);
      end
      late = 0;
      PREADY = 1'b1; PSLVERR = 1'b1;
      repeat (3) begin
         @(negedge PCLK);
         if (rsp_valid !== 1'b0 || PSEL !== 1'b0) late++;
      end
      PREADY = 1'b0; PSLVERR = 1'b0;
      n_vec++;
      if (late != 0) begin n_err++; $display("FAIL to_late_pready: %0d cycles with activity, want 0", late); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs[3];
      logic [31:0] seen[$];
      int setup_cyc[$];
      int done, i;
      bit pend;
      for (int k = 0; k < 3; k++) addrs[k] = {$urandom, 2'b00} + 32'(k);
      done = 0; i = 0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addrs[0]; cmd_wdata = $urandom; PREADY = 1'b1;
      pend = (cmd_ready === 1'b1);
      for (int c = 0; c < 40 && done < 3; c++) begin
         @(negedge PCLK);
         if (pend) begin
            i++;
            if (i < 3) begin cmd_addr = addrs[i]; cmd_wdata = $urandom; end
            else cmd_valid = 1'b0;
         end
         if (PSEL === 1'b1 && PENABLE === 1'b0) begin seen.push_back(PADDR); setup_cyc.push_back(c); end
         if (rsp_valid === 1'b1) done++;
         pend = cmd_valid && (cmd_ready === 1'b1);
      end
      cmd_valid = 1'b0; PREADY = 1'b0;
      @(negedge PCLK);
      n_vec++;
      if (done != 3 || seen.size() != 3) begin
         n_err++; $display("FAIL b2b_count: rsp=%0d setups=%0d, want 3/3", done, seen.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (seen[k] !== addrs[k]) begin n_err++; $display("FAIL b2b_addr%0d: got %h want %h", k, seen[k], addrs[k]); end
         end
         n_vec++;
         if (setup_cyc[1] - setup_cyc[0] != 3 || setup_cyc[2] - setup_cyc[1] != 3) begin
            n_err++; $display("FAIL b2b_spacing: gaps %0d,%0d want 3,3", setup_cyc[1] - setup_cyc[0], setup_cyc[2] - setup_cyc[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      int seen;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = $urandom; PREADY = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      n_vec++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin n_err++; $display("FAIL rst_mid_access: psel=%b pen=%b, want 1/1", PSEL, PENABLE); end
      #2 PRESETn = 1'b0;
      #1;
      n_vec++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid} !== '0) begin
         n_err++; $display("FAIL rst_mid_drop: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b, want all 0",
                           PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid);
      end
      seen = 0;
      repeat (3) begin @(negedge PCLK); if (rsp_valid !== 1'b0) seen++; end
      PRESETn = 1'b1;
      n_vec++;
      if (seen != 0) begin n_err++; $display("FAIL rst_mid_rsp: %0d rsp_valid cycles, want 0", seen); end
      xfer(1'b0, 32'h44, 32'h0, 1, 1'b0, 32'hCAFE_0044, o);
      n_vec++;
      if (!o.got || o.lat != 4 || o.rd !== 32'hCAFE_0044 || o.err !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_after: got=%0b lat=%0d rd=%h err=%b, want 1/4/cafe0044/0", o.got, o.lat, o.rd, o.err);
      end
   endtask

   task automatic test_random();
      obs_t o;
      logic wr, err;
      logic [31:0] a, wd, rd, erd;
      logic eerr;
      int waits;
      for (int n = 0; n < 25; n++) begin
         wr = 1'($urandom); err = 1'($urandom); a = $urandom; wd = $urandom; rd = $urandom;
         waits = (n % 6 == 5) ? int'($urandom_range(TIMEOUT, TIMEOUT + 4)) : int'($urandom_range(0, 6));
         xfer(wr, a, wd, waits, err, rd, o);
         erd  = (wr || is_to(waits)) ? 32'h0 : rd;
         eerr = is_to(waits) ? 1'b1 : err;
         n_vec++;
         if (!o.got || o.lat != exp_lat(waits) || o.pen_n != exp_pen(waits) || o.psel_n != exp_lat(waits) - 1) begin
            n_err++; $display("FAIL rnd%0d_timing: got=%0b lat=%0d pen=%0d psel=%0d, want 1/%0d/%0d/%0d",
                              n, o.got, o.lat, o.pen_n, o.psel_n, exp_lat(waits), exp_pen(waits), exp_lat(waits) - 1);
         end
         n_vec++;
         if (o.rd !== erd || o.err !== eerr || !o.stable || !o.next_lo || !o.setup_ok) begin
            n_err++; $display("FAIL rnd%0d_rsp: rd=%h err=%b stable=%0b pulse1=%0b setup=%0b, want %h/%b/1/1/1",
                              n, o.rd, o.err, o.stable, o.next_lo, o.setup_ok, erd, eerr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
